cdc_test_sequencer: RTL and testbench

CDC_TEST_SEQUENCER -- requirements
Module: cdc_test_sequencer

---
 rtl/cdc_test_sequencer_pkg.sv | 21 ++
 rtl/cdc_test_sequencer_hs_timer.sv | 33 +++
 rtl/cdc_test_sequencer.sv | 145 ++++++++++++++
 tb/tb_cdc_test_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_test_sequencer_pkg.sv
// Shared definitions for the CDC test sequencer.
// Holds the sequencer state encoding, the word width sent to the receiver
// and the width of the word/error/phase counters, plus a saturating
// increment helper for the error counter.
package cdc_test_sequencer_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/cdc_test_sequencer_hs_timer.sv
// hs_timer: per-phase handshake watchdog.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clear   - restart the phase (count back to zero)
//   enable  - count this cycle
//   expired - count has reached TIMEOUT
module hs_timer
  import cdc_test_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // The count parks at TIMEOUT; the sequencer clears it when it aborts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cdc_test_sequencer.sv
// cdc_test_sequencer: drives a counting word stream across a 4-phase
// req/ack handshake and tallies receiver mismatches during the run.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset, overrides everything
//   start    - one-cycle pulse that starts a run (ignored while busy)
//   req      - 4-phase request toward the sender path
//   data     - word presented with req (counts 1,2,... modulo 16)
//   ack      - 4-phase acknowledge, already synchronized
//   failure  - receiver mismatch flag, counted while busy
//   busy     - run in progress
//   done     - one-cycle pulse at end of run
//   err_cnt  - saturating count of failure cycles in the current run
//   timeout  - sticky: the run aborted on a handshake timeout
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for start; err_cnt/timeout hold last run result
// ST_SEND    | req high, data stable, waiting for ack high
// ST_RELEASE | req low, waiting for ack low
// ST_FINISH  | done pulse, back to idle next cycle
module cdc_test_sequencer
  import cdc_test_sequencer_pkg::*;
#(
  parameter int N_WORDS = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              req,
  output logic [DATA_W-1:0] data,
  input  logic              ack,
  input  logic              failure,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              timeout
);

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic             timer_clear;
  logic             timer_en;
  logic             timer_expired;

  // The timer restarts whenever the handshake phase is about to change,
  // so each SEND/RELEASE visit gets its own TIMEOUT budget.
  always_comb begin
    timer_clear = 1'b1;
    case (state)
      ST_SEND:    timer_clear = ack || timer_expired;
      ST_RELEASE: timer_clear = !ack || timer_expired;
      default:    timer_clear = 1'b1;
    endcase
  end

  assign timer_en = (state == ST_SEND) || (state == ST_RELEASE);

  hs_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hs_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req      <= 1'b0;
      data     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      timeout  <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (state != ST_IDLE && failure) begin
        err_cnt <= sat_inc(err_cnt);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SEND;
            req      <= 1'b1;
            busy     <= 1'b1;
            data     <= DATA_W'(1);
            word_cnt <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
          end
        end

        // Expiry is tested before ack so a late ack cannot rescue the phase.
        ST_SEND: begin
          if (timer_expired) begin
            state   <= ST_FINISH;
            req     <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (ack) begin
            state    <= ST_RELEASE;
            req      <= 1'b0;
            word_cnt <= word_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (timer_expired) begin
            state   <= ST_FINISH;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (!ack) begin
            if (word_cnt == CNT_W'(N_WORDS)) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_SEND;
              req   <= 1'b1;
              data  <= data + 1'b1;
            end
          end
        end

        ST_FINISH: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_test_sequencer.sv
module tb_cdc_test_sequencer;

  localparam int NW = 20;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       failure = 1'b0;
  logic       req, busy, done, timeout;
  logic [3:0] data;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cdc_test_sequencer #(
    .N_WORDS (NW),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .failure (failure),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .timeout (timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ack responder ----------------
  bit ack_en = 1'b0;
  bit ack_stuck = 1'b0;
  bit rand_lat = 1'b0;
  int lat = 3;
  int rcnt = 0;

  always @(negedge clk) begin
    if (!ack_en) begin
      ack = 1'b0;
      rcnt = 0;
    end else if (req && !ack) begin
      rcnt++;
      if (rcnt >= lat) begin
        ack = 1'b1;
        rcnt = 0;
        if (rand_lat) lat = $urandom_range(1, 7);
      end
    end else if (!req && ack && !ack_stuck) begin
      rcnt++;
      if (rcnt >= lat) begin
        ack = 1'b0;
        rcnt = 0;
        if (rand_lat) lat = $urandom_range(1, 7);
      end
    end else begin
      rcnt = 0;
    end
  end

  // ---------------- word sequence monitor ----------------
  int  seq[$];
  logic req_q = 1'b0;

  always @(negedge clk) begin
    if (req && !req_q) seq.push_back(int'(data));
    req_q = req;
  end

  function automatic int seq_at(input int i);
    if (i < seq.size()) return seq[i];
    return -1;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_hs: inside the handshake portion of a run; m_req: request phase.
  bit m_run = 0, m_hs = 0, m_req = 0, m_fin = 0, m_to = 0;
  int m_words = 0, m_age = 0, m_err = 0, m_data = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_hs = 0; m_req = 0; m_fin = 0; m_to = 0;
      m_words = 0; m_age = 0; m_err = 0; m_data = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_hs = 1; m_req = 1; m_fin = 0; m_to = 0;
        m_words = 0; m_age = 0; m_err = 0; m_data = 1;
      end
    end else begin
      if (failure && m_err < 255) m_err++;
      if (m_fin) begin
        m_fin = 0;
        m_run = 0;
      end else if (m_age == TO) begin
        m_to = 1; m_hs = 0; m_req = 0; m_fin = 1;
      end else if (m_req && ack) begin
        m_words++;
        m_req = 0;
        m_age = 0;
      end else if (!m_req && !ack) begin
        if (m_words == NW) begin
          m_hs = 0;
          m_fin = 1;
        end else begin
          m_req = 1;
          m_age = 0;
          m_data = (m_words + 1) % 16;
        end
      end else begin
        m_age++;
      end
    end
    #2;
    chk("req", int'(req), int'(m_req));
    chk("data", int'(data), m_data);
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_fin));
    chk("err_cnt", int'(err_cnt), m_err);
    chk("timeout", int'(timeout), int'(m_to));
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(done), 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_to", int'(timeout), 0);
    rst = 1'b0;
    ack_en = 1'b1;
    lat = 3;

    // plain run, 20 words, data wraps through 0
    seq.delete();
    pulse_start();
    wait_done(800, "run1_done");
    chk("run1_words", seq.size(), 20);
    chk("run1_w0", seq_at(0), 1);
    chk("run1_w14", seq_at(14), 15);
    chk("run1_w15", seq_at(15), 0);
    chk("run1_w19", seq_at(19), 4);
    chk("run1_err", int'(err_cnt), 0);
    chk("run1_to", int'(timeout), 0);

    // restart in the idle cycle right after done; 3 failures + stray start
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    seq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run2_data0", int'(data), 1);
    repeat (3) @(negedge clk);
    repeat (3) begin
      failure = 1'b1;
      @(negedge clk);
      failure = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (!(req && !ack) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("run2_req_seen", int'(req), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(800, "run2_done");
    chk("run2_words", seq.size(), 20);
    chk("run2_w19", seq_at(19), 4);
    chk("run2_err", int'(err_cnt), 3);

    // err_cnt holds in idle, clears on next start; failure held -> saturate
    @(negedge clk);
    chk("run2_err_hold", int'(err_cnt), 3);
    lat = 8;
    start = 1'b1;
    failure = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run3_err_clr", int'(err_cnt), 0);
    wait_done(1000, "run3_done");
    failure = 1'b0;
    chk("run3_err_sat", int'(err_cnt), 255);

    // ack never arrives: abort after TIMEOUT
    @(negedge clk);
    ack_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_req_up", int'(req), 1);
    chk("to_err_clr", int'(err_cnt), 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency_ok", int'(n >= 10 && n <= 11), 1);
    chk("to_flag", int'(timeout), 1);
    chk("to_req_low", int'(req), 0);
    @(negedge clk);
    chk("to_hold", int'(timeout), 1);
    chk("to_idle", int'(busy), 0);

    // restart right after done; ack lands on the expiry cycle -> timeout wins
    ack_en = 1'b1;
    lat = 11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("coll_to_clr", int'(timeout), 0);
    wait_done(100, "coll_done");
    chk("coll_to", int'(timeout), 1);
    chk("coll_data", int'(data), 1);
    repeat (15) @(negedge clk);

    // ack stuck high: abort during release phase
    lat = 2;
    ack_stuck = 1'b1;
    seq.delete();
    pulse_start();
    wait_done(100, "rel_to_done");
    chk("rel_to_flag", int'(timeout), 1);
    chk("rel_to_words", seq.size(), 1);
    ack_stuck = 1'b0;
    ack_en = 1'b0;
    repeat (2) @(negedge clk);
    ack_en = 1'b1;

    // reset in release phase
    lat = 3;
    pulse_start();
    n = 0;
    while (!(busy && !req && !done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_rel_seen", int'(busy && !req), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstr_req", int'(req), 0);
    chk("rstr_data", int'(data), 0);
    chk("rstr_busy", int'(busy), 0);
    chk("rstr_done", int'(done), 0);
    chk("rstr_err", int'(err_cnt), 0);
    chk("rstr_to", int'(timeout), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // randomized runs
    rand_lat = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int mode;
      mode = $urandom_range(0, 3);
      ack_en = (mode != 3);
      ack_stuck = (mode == 2);
      lat = $urandom_range(1, 7);
      pulse_start();
      n = 0;
      while (done !== 1'b1 && n < 1000) begin
        @(negedge clk);
        failure = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 15) == 0);
        n++;
      end
      chk("rand_done", int'(done), 1);
      @(negedge clk);
      start = 1'b0;
      failure = ($urandom_range(0, 1) == 1);
      ack_stuck = 1'b0;
      ack_en = 1'b0;
      repeat ($urandom_range(2, 4)) @(negedge clk);
      failure = 1'b0;
      ack_en = 1'b1;
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
